// File: rtl/spy_bus_master_if.sv
// Requester and spy-bus signals of spy_bus_master, bundled into one interface.
// master = view from the bus master; slave = view from requesters, the decoder and the bench.
interface spy_bus_master_if;
  logic        req0_valid;
  logic        req0_ready;
  logic        req0_write;
  logic [4:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        rsp0_valid;
  logic [15:0] rsp0_rdata;
  logic        req1_valid;
  logic        req1_ready;
  logic        req1_write;
  logic [4:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic        rsp1_valid;
  logic [15:0] rsp1_rdata;
  logic [4:0]  eadr;
  logic        dbread;
  logic        dbwrite;
  logic [15:0] spy_wdata;
  logic [15:0] spy_rdata;
  logic        busy;

  // Handshake: a request transfers on a cycle where reqN_valid & reqN_ready are both 1.
  // reqN_ready depends combinationally on the valids. rspN_valid is a one-cycle pulse
  // and cannot be stalled.
  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  spy_rdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output eadr, dbread, dbwrite, spy_wdata, busy
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output spy_rdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  eadr, dbread, dbwrite, spy_wdata, busy
  );
endinterface

// File: rtl/spy_bus_master.sv
// Round-robin, two-port master for the CADR spy (PDP11 examine) bus.
// Each transaction runs IDLE -> SETUP -> STROBE -> HOLD -> RESP, and every bus output is registered.
module spy_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  spy_bus_master_if.master  bus,
  output logic [2:0]        o_dbg_state
);
  localparam int MAX_AB = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_P  = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int CW     = $clog2(MAX_P + 1);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_RESP} state_t;

  state_t        r_state, w_next_state;
  logic [CW-1:0] r_cnt, w_next_cnt;
  logic          r_rr, r_write, r_owner;
  logic [4:0]    r_eadr;
  logic [15:0]   r_spy_wdata, r_cap, r_rsp0_rdata, r_rsp1_rdata;
  logic          r_dbread, r_dbwrite, r_rsp0_valid, r_rsp1_valid;

  logic          w_grant0, w_grant1, w_last;
  logic          w_rr, w_write, w_owner;
  logic [4:0]    w_eadr;
  logic [15:0]   w_spy_wdata, w_cap, w_rsp0_rdata, w_rsp1_rdata;
  logic          w_dbread, w_dbwrite, w_rsp0_valid, w_rsp1_valid;

  assign w_last = (r_cnt == '0);

  // The rr pointer only breaks ties; a lone valid requester always wins.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == ST_IDLE) begin
      w_grant0 = bus.req0_valid & (~bus.req1_valid | ~r_rr);
      w_grant1 = bus.req1_valid & (~bus.req0_valid | r_rr);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_rr         <= 1'b0;
      r_write      <= 1'b0;
      r_owner      <= 1'b0;
      r_eadr       <= '0;
      r_spy_wdata  <= '0;
      r_cap        <= '0;
      r_dbread     <= 1'b0;
      r_dbwrite    <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_rr         <= w_rr;
      r_write      <= w_write;
      r_owner      <= w_owner;
      r_eadr       <= w_eadr;
      r_spy_wdata  <= w_spy_wdata;
      r_cap        <= w_cap;
      r_dbread     <= w_dbread;
      r_dbwrite    <= w_dbwrite;
      r_rsp0_valid <= w_rsp0_valid;
      r_rsp1_valid <= w_rsp1_valid;
      r_rsp0_rdata <= w_rsp0_rdata;
      r_rsp1_rdata <= w_rsp1_rdata;
    end
  end

  // The phase counter reloads on entry to each timed state and counts down to zero.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant0 | w_grant1) begin
          w_next_state = ST_SETUP;
          w_next_cnt   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (w_last) begin
          w_next_state = ST_STROBE;
          w_next_cnt   = STROBE_LD;
        end else begin
          w_next_cnt = r_cnt - CW'(1);
        end
      end
      ST_STROBE: begin
        if (w_last) begin
          w_next_state = ST_HOLD;
          w_next_cnt   = HOLD_LD;
        end else begin
          w_next_cnt = r_cnt - CW'(1);
        end
      end
      ST_HOLD: begin
        if (w_last) begin
          w_next_state = ST_RESP;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt - CW'(1);
        end
      end
      ST_RESP: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state, so the registered strobes line up with the states.
  always_comb begin
    w_rr         = r_rr;
    w_write      = r_write;
    w_owner      = r_owner;
    w_eadr       = r_eadr;
    w_spy_wdata  = r_spy_wdata;
    w_cap        = r_cap;
    w_dbread     = 1'b0;
    w_dbwrite    = 1'b0;
    w_rsp0_valid = 1'b0;
    w_rsp1_valid = 1'b0;
    w_rsp0_rdata = r_rsp0_rdata;
    w_rsp1_rdata = r_rsp1_rdata;
    if (w_grant0) begin
      w_write     = bus.req0_write;
      w_owner     = 1'b0;
      w_rr        = 1'b1;
      w_eadr      = bus.req0_addr;
      w_spy_wdata = bus.req0_write ? bus.req0_wdata : 16'h0000;
    end else if (w_grant1) begin
      w_write     = bus.req1_write;
      w_owner     = 1'b1;
      w_rr        = 1'b0;
      w_eadr      = bus.req1_addr;
      w_spy_wdata = bus.req1_write ? bus.req1_wdata : 16'h0000;
    end
    if (w_next_state == ST_STROBE) begin
      w_dbread  = ~r_write;
      w_dbwrite = r_write;
    end
    if ((r_state == ST_STROBE) && w_last && !r_write) begin
      w_cap = bus.spy_rdata;
    end
    if (w_next_state == ST_RESP) begin
      if (r_owner) begin
        w_rsp1_valid = 1'b1;
        w_rsp1_rdata = r_write ? 16'h0000 : r_cap;
      end else begin
        w_rsp0_valid = 1'b1;
        w_rsp0_rdata = r_write ? 16'h0000 : r_cap;
      end
    end
  end

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp0_rdata = r_rsp0_rdata;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp1_rdata = r_rsp1_rdata;
  assign bus.eadr       = r_eadr;
  assign bus.dbread     = r_dbread;
  assign bus.dbwrite    = r_dbwrite;
  assign bus.spy_wdata  = r_spy_wdata;
  assign bus.busy       = (r_state != ST_IDLE);
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_spy_bus_master.sv
// Bench for spy_bus_master: directed vectors, hand-written corner sequences, and random traffic
// checked against a transaction-level timing model. A second instance uses non-default phase lengths.
module tb_spy_bus_master;
  localparam int S_A = 1, T_A = 2, H_A = 1;
  localparam int LAT_A = S_A + T_A + H_A + 1;
  localparam int S_B = 3, T_B = 1, H_B = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] dbg_a, dbg_b;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  spy_bus_master_if bus_a ();
  spy_bus_master_if bus_b ();

  spy_bus_master #(.SETUP_CYC(S_A), .STROBE_CYC(T_A), .HOLD_CYC(H_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .o_dbg_state(dbg_a));
  spy_bus_master #(.SETUP_CYC(S_B), .STROBE_CYC(T_B), .HOLD_CYC(H_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .o_dbg_state(dbg_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // spy_rdata of instance A is either a fixed value or a fresh random word every cycle
  logic        rnd_on = 1'b0;
  logic [15:0] rnd_val = 16'h0;
  logic [15:0] fixed_val = 16'h0;
  assign bus_a.spy_rdata = rnd_on ? rnd_val : fixed_val;
  initial forever begin
    @(posedge clk);
    #1 rnd_val = 16'($urandom);
  end

  // model state and observation logs
  logic        m_act = 1'b0, m_pref = 1'b0, m_wr = 1'b0;
  int          m_t = 0, m_port = 0;
  logic [4:0]  m_addr = '0, m_eadr = '0;
  logic [15:0] m_wdat = '0, m_swd = '0, m_cap = '0;
  logic [15:0] m_rd [2];
  int          acc_cyc_q[$], acc_port_q[$], rsp_cyc_q[$], rsp_port_q[$];
  logic [15:0] rsp_data_q[$];
  int          st_rd = 0, st_wr = 0;
  logic        pa_st = 1'b0, pb_st = 1'b0;
  logic [4:0]  pa_e = '0, pb_e = '0;

  typedef struct {
    int          port;
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rd_drv;
    logic [15:0] exp_rdata;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: a granted transaction occupies the bus for LAT_A cycles after the
  // grant cycle, with phase boundaries computed from the phase lengths.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_act = 1'b0; m_pref = 1'b0; m_eadr = '0; m_swd = '0; m_cap = '0;
        m_rd[0] = '0; m_rd[1] = '0; pa_st = 1'b0; pb_st = 1'b0;
      end else begin : live
        int d;
        logic e_rd, e_wr, e_busy, e_rdy0, e_rdy1, done;
        logic [1:0] e_rv;
        d = 0; e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0; done = 1'b0; e_rv = 2'b00;
        if (m_act) begin
          d = cyc - m_t;
          e_busy = 1'b1;
          if (d == 1) begin
            m_eadr = m_addr;
            m_swd  = m_wr ? m_wdat : 16'h0;
          end
          if (d > S_A && d <= S_A + T_A) begin
            e_rd = ~m_wr;
            e_wr = m_wr;
          end
          if (d == S_A + T_A && !m_wr) m_cap = bus_a.spy_rdata;
          if (d == LAT_A) begin
            m_rd[m_port] = m_wr ? 16'h0 : m_cap;
            e_rv[m_port] = 1'b1;
            done = 1'b1;
          end
        end
        e_rdy0 = !m_act && bus_a.req0_valid && (!bus_a.req1_valid || !m_pref);
        e_rdy1 = !m_act && bus_a.req1_valid && (!bus_a.req0_valid || m_pref);
        check("eadr", bus_a.eadr, m_eadr);
        check("spy_wdata", bus_a.spy_wdata, m_swd);
        check("dbread", bus_a.dbread, e_rd);
        check("dbwrite", bus_a.dbwrite, e_wr);
        check("busy", bus_a.busy, e_busy);
        check("req0_ready", bus_a.req0_ready, e_rdy0);
        check("req1_ready", bus_a.req1_ready, e_rdy1);
        check("rsp0_valid", bus_a.rsp0_valid, e_rv[0]);
        check("rsp1_valid", bus_a.rsp1_valid, e_rv[1]);
        check("rsp0_rdata", bus_a.rsp0_rdata, m_rd[0]);
        check("rsp1_rdata", bus_a.rsp1_rdata, m_rd[1]);
        // strobe rules on both instances
        check("a_strobe_excl", bus_a.dbread & bus_a.dbwrite, 1'b0);
        if (pa_st || bus_a.dbread || bus_a.dbwrite) check("a_eadr_stable", bus_a.eadr, pa_e);
        pa_st = bus_a.dbread | bus_a.dbwrite;
        pa_e  = bus_a.eadr;
        check("b_strobe_excl", bus_b.dbread & bus_b.dbwrite, 1'b0);
        if (pb_st || bus_b.dbread || bus_b.dbwrite) check("b_eadr_stable", bus_b.eadr, pb_e);
        pb_st = bus_b.dbread | bus_b.dbwrite;
        pb_e  = bus_b.eadr;
        // observation logs from the DUT side
        if (bus_a.dbread)  st_rd++;
        if (bus_a.dbwrite) st_wr++;
        if (bus_a.req0_valid && bus_a.req0_ready) begin
          acc_cyc_q.push_back(cyc); acc_port_q.push_back(0); st_rd = 0; st_wr = 0;
        end
        if (bus_a.req1_valid && bus_a.req1_ready) begin
          acc_cyc_q.push_back(cyc); acc_port_q.push_back(1); st_rd = 0; st_wr = 0;
        end
        if (bus_a.rsp0_valid) begin
          rsp_cyc_q.push_back(cyc); rsp_port_q.push_back(0); rsp_data_q.push_back(bus_a.rsp0_rdata);
        end
        if (bus_a.rsp1_valid) begin
          rsp_cyc_q.push_back(cyc); rsp_port_q.push_back(1); rsp_data_q.push_back(bus_a.rsp1_rdata);
        end
        if (done) m_act = 1'b0;
        if (e_rdy0 || e_rdy1) begin
          m_act  = 1'b1;
          m_t    = cyc;
          m_port = e_rdy1 ? 1 : 0;
          m_wr   = e_rdy1 ? bus_a.req1_write : bus_a.req0_write;
          m_addr = e_rdy1 ? bus_a.req1_addr  : bus_a.req0_addr;
          m_wdat = e_rdy1 ? bus_a.req1_wdata : bus_a.req0_wdata;
          m_pref = e_rdy0;
        end
      end
    end
  endtask

  // Raises valid on port p of instance A and holds it until accepted.
  task automatic send(input int p, input logic w, input logic [4:0] a, input logic [15:0] d);
    int  n;
    logic ok;
    n = 0; ok = 1'b0;
    if (p == 0) begin
      bus_a.req0_write = w; bus_a.req0_addr = a; bus_a.req0_wdata = d; bus_a.req0_valid = 1'b1;
    end else begin
      bus_a.req1_write = w; bus_a.req1_addr = a; bus_a.req1_wdata = d; bus_a.req1_valid = 1'b1;
    end
    while (!ok && n < 100) begin
      @(negedge clk);
      n++;
      ok = (p == 0) ? bus_a.req0_ready : bus_a.req1_ready;
    end
    if (!ok) check("accept_timeout", ok, 1'b1);
    @(posedge clk);
    #1;
    if (p == 0) bus_a.req0_valid = 1'b0;
    else        bus_a.req1_valid = 1'b0;
  endtask

  task automatic wait_rsps(input int target);
    int n;
    n = 0;
    while (rsp_cyc_q.size() < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (rsp_cyc_q.size() < target) check("rsp_timeout", rsp_cyc_q.size(), target);
  endtask

  task automatic rnd_port(input int p, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom));
    end
  endtask

  initial begin
    int i0, r0, n, t_acc, first_st, last_st, t_rsp, c0, c1;
    logic ok;
    logic [4:0]  eadr_at1;
    logic [15:0] rd_b;
    bus_a.req0_valid = 1'b0; bus_a.req0_write = 1'b0; bus_a.req0_addr = '0; bus_a.req0_wdata = '0;
    bus_a.req1_valid = 1'b0; bus_a.req1_write = 1'b0; bus_a.req1_addr = '0; bus_a.req1_wdata = '0;
    bus_b.req0_valid = 1'b0; bus_b.req0_write = 1'b0; bus_b.req0_addr = '0; bus_b.req0_wdata = '0;
    bus_b.req1_valid = 1'b0; bus_b.req1_write = 1'b0; bus_b.req1_addr = '0; bus_b.req1_wdata = '0;
    bus_b.spy_rdata  = '0;
    vecs[0] = '{0, 1'b0, 5'h04, 16'h0000, 16'hBEEF, 16'hBEEF};
    vecs[1] = '{1, 1'b1, 5'h06, 16'h1234, 16'hFFFF, 16'h0000};
    vecs[2] = '{1, 1'b0, 5'h1F, 16'hAAAA, 16'h5A5A, 16'h5A5A};
    vecs[3] = '{0, 1'b1, 5'h00, 16'hFFFF, 16'h1111, 16'h0000};
    vecs[4] = '{0, 1'b0, 5'h00, 16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{1, 1'b0, 5'h11, 16'h0000, 16'h8001, 16'h8001};
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("rst_state_a", dbg_a, 3'd0);
    check("rst_state_b", dbg_b, 3'd0);
    check("rst_eadr", bus_a.eadr, 5'h0);
    check("rst_strobes", {bus_a.dbread, bus_a.dbwrite}, 2'b00);
    check("rst_busy", bus_a.busy, 1'b0);

    // directed vectors
    for (int v = 0; v < 6; v++) begin
      @(posedge clk);
      #1 fixed_val = vecs[v].rd_drv;
      r0 = rsp_cyc_q.size();
      send(vecs[v].port, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      wait_rsps(r0 + 1);
      if (rsp_cyc_q.size() > r0) begin
        check("vec_rsp_port", rsp_port_q[r0], vecs[v].port);
        check("vec_rdata", rsp_data_q[r0], vecs[v].exp_rdata);
        check("vec_latency", rsp_cyc_q[r0] - acc_cyc_q[$], LAT_A);
        check("vec_dbread_cycles", st_rd, vecs[v].wr ? 0 : T_A);
        check("vec_dbwrite_cycles", st_wr, vecs[v].wr ? T_A : 0);
      end
    end

    // back-to-back reads on port 0
    @(posedge clk);
    #1 fixed_val = 16'hC0DE;
    i0 = acc_cyc_q.size();
    r0 = rsp_cyc_q.size();
    send(0, 1'b0, 5'h08, 16'h0);
    send(0, 1'b0, 5'h0F, 16'h0);
    wait_rsps(r0 + 2);
    if (acc_cyc_q.size() >= i0 + 2 && rsp_cyc_q.size() >= r0 + 2) begin
      check("b2b_period", acc_cyc_q[i0 + 1] - acc_cyc_q[i0], LAT_A + 1);
      check("b2b_after_resp", acc_cyc_q[i0 + 1], rsp_cyc_q[r0] + 1);
      check("b2b_rdata2", rsp_data_q[r0 + 1], 16'hC0DE);
    end

    // reset in the middle of a write strobe
    @(posedge clk);
    #1;
    send(0, 1'b1, 5'h0A, 16'hCAFE);
    n = 0;
    while (!bus_a.dbwrite && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_strobe", bus_a.dbwrite, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_dbwrite_drop", bus_a.dbwrite, 1'b0);
    check("rst_busy_drop", bus_a.busy, 1'b0);
    check("rst_spy_wdata", bus_a.spy_wdata, 16'h0);
    r0 = rsp_cyc_q.size();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_no_rsp", rsp_cyc_q.size(), r0);
    check("rst_idle", dbg_a, 3'd0);

    // both requesters continuously valid, starting from the reset pointer
    i0 = acc_port_q.size();
    c0 = 0; c1 = 0;
    @(posedge clk);
    #1;
    fork
      begin send(0, 1'b0, 5'h02, 16'h0); send(0, 1'b1, 5'h03, 16'h0F0F); end
      begin send(1, 1'b1, 5'h12, 16'h5555); send(1, 1'b0, 5'h13, 16'h0); end
    join
    wait_rsps(r0 + 4);
    if (acc_port_q.size() >= i0 + 4) begin
      check("alt_grant0", acc_port_q[i0], 0);
      check("alt_grant1", acc_port_q[i0 + 1], 1);
      check("alt_grant2", acc_port_q[i0 + 2], 0);
      check("alt_grant3", acc_port_q[i0 + 3], 1);
    end
    for (int k = r0; k < rsp_port_q.size(); k++) begin
      if (rsp_port_q[k] == 0) c0++;
      else c1++;
    end
    check("alt_rsp_cnt0", c0, 2);
    check("alt_rsp_cnt1", c1, 2);

    // random traffic on both ports with a changing spy_rdata
    rnd_on = 1'b1;
    r0 = rsp_cyc_q.size();
    @(posedge clk);
    #1;
    fork
      rnd_port(0, 25);
      rnd_port(1, 25);
    join
    wait_rsps(r0 + 50);
    check("rnd_rsp_total", rsp_cyc_q.size() - r0, 50);
    rnd_on = 1'b0;

    // instance B: SETUP 3, STROBE 1, HOLD 2
    @(posedge clk);
    #1;
    bus_b.spy_rdata = 16'h7E57;
    bus_b.req0_addr = 5'h13; bus_b.req0_write = 1'b0; bus_b.req0_valid = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      ok = bus_b.req0_ready;
    end
    check("b_accept", ok, 1'b1);
    t_acc = cyc;
    @(posedge clk);
    #1 bus_b.req0_valid = 1'b0;
    first_st = -1; last_st = -1; t_rsp = -1; eadr_at1 = '0; rd_b = '0; n = 0;
    while (t_rsp < 0 && n < 30) begin
      @(negedge clk);
      n++;
      if (cyc == t_acc + 1) eadr_at1 = bus_b.eadr;
      if (bus_b.dbread) begin
        if (first_st < 0) first_st = cyc;
        last_st = cyc;
      end
      if (bus_b.rsp0_valid) begin
        t_rsp = cyc;
        rd_b  = bus_b.rsp0_rdata;
      end
      check("b_rsp1_quiet", bus_b.rsp1_valid, 1'b0);
    end
    check("b_eadr_setup", eadr_at1, 5'h13);
    check("b_lead", first_st - (t_acc + 1), S_B);
    check("b_strobe_width", last_st - first_st + 1, T_B);
    check("b_trail", t_rsp - last_st - 1, H_B);
    check("b_rdata", rd_b, 16'h7E57);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
